// File: rtl/mux_3x1_64b_pkg.sv
// rtl/mux_3x1_64b_pkg.sv - shared constants for the 3:1 immediate selector
// Purpose: select encodings and default data width used by mux_3x1_64b.
// Ports: none (package).
package mux_3x1_64b_pkg;

  localparam int DEFAULT_WIDTH = 64;

  localparam logic [1:0] SEL_A       = 2'b00;
  localparam logic [1:0] SEL_B       = 2'b01;
  localparam logic [1:0] SEL_C       = 2'b10;
  localparam logic [1:0] SEL_ILLEGAL = 2'b11;

endpackage

// File: rtl/mux_3x1_64b_mux_2x1.sv
// rtl/mux_3x1_64b_mux_2x1.sv - parameterised 2:1 selector stage
// Purpose: one level of the two-level 3:1 selection tree.
// Ports:
//   i_d0  [WIDTH]  value passed when i_sel = 0
//   i_d1  [WIDTH]  value passed when i_sel = 1
//   i_sel [1]      select
//   o_y   [WIDTH]  selected value (combinational)
module mux_2x1_64bit
  import mux_3x1_64b_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mux_3x1_64b.sv
// rtl/mux_3x1_64b.sv - 3:1 immediate selector with registered copy and select-error flag
// Purpose: picks A/B/C by S for the immediate generator; S = 11 yields zero.
// Ports:
//   clk       [1]      clock, registers update on rising edge
//   rst       [1]      synchronous active-high reset
//   A, B, C   [WIDTH]  operands for S = 00 / 01 / 10
//   S         [2]      select
//   X         [WIDTH]  combinational selected value
//   X_q       [WIDTH]  X registered one cycle
//   sel_err_q [1]      registered flag, previous cycle's S was 11
module mux_3x1_64b
  import mux_3x1_64b_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] X_q,
  output logic             sel_err_q
);

  logic [WIDTH-1:0] w_ab;
  logic [WIDTH-1:0] w_abc;
  logic             w_illegal;
  logic [WIDTH-1:0] r_x_q;
  logic             r_sel_err_q;

  mux_2x1_64bit #(.WIDTH(WIDTH)) u_stage0 (
    .i_d0  (A),
    .i_d1  (B),
    .i_sel (S[0]),
    .o_y   (w_ab)
  );

  mux_2x1_64bit #(.WIDTH(WIDTH)) u_stage1 (
    .i_d0  (w_ab),
    .i_d1  (C),
    .i_sel (S[1]),
    .o_y   (w_abc)
  );

  assign w_illegal = (S == SEL_ILLEGAL);

  // The tree alone would pass C on S = 11; force a defined zero instead.
  assign X = w_illegal ? '0 : w_abc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_q       <= '0;
      r_sel_err_q <= 1'b0;
    end else begin
      r_x_q       <= X;
      r_sel_err_q <= w_illegal;
    end
  end

  assign X_q       = r_x_q;
  assign sel_err_q = r_sel_err_q;

endmodule

// File: tb/tb_mux_3x1_64b.sv
// tb/tb_mux_3x1_64b.sv - self-checking bench for mux_3x1_64b
module tb_mux_3x1_64b;

  localparam logic [63:0] VA = 64'h0000_0000_0000_0123;
  localparam logic [63:0] VB = 64'hFFFF_FFFF_FFFF_F800;
  localparam logic [63:0] VC = 64'h0000_0000_0000_0FFE;

  logic        clk;
  logic        rst;
  logic [63:0] A, B, C;
  logic [1:0]  S;
  logic [63:0] X, X_q;
  logic        sel_err_q;

  int checks;
  int errors;

  mux_3x1_64b #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .C         (C),
    .S         (S),
    .X         (X),
    .X_q       (X_q),
    .sel_err_q (sel_err_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] c, input logic [1:0] s);
    case (s)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return c;
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] exp_x;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    A = VA; B = VB; C = VC; S = 2'b00;

    // reset state
    tick();
    check("reset_x_q", X_q, 64'd0);
    check("reset_err", {63'd0, sel_err_q}, 64'd0);
    rst = 1'b0;

    // legal selects, combinational only
    S = 2'b00; #1; check("comb_s00", X, VA);
    S = 2'b01; #1; check("comb_s01", X, VB);
    S = 2'b10; #1; check("comb_s10", X, VC);

    // illegal select and recovery
    S = 2'b11; #1; check("comb_s11", X, 64'd0);
    tick();
    check("illegal_err", {63'd0, sel_err_q}, 64'd1);
    check("illegal_x_q", X_q, 64'd0);
    S = 2'b00;
    tick();
    check("recover_err", {63'd0, sel_err_q}, 64'd0);
    check("recover_x_q", X_q, VA);

    // back-to-back latency
    S = 2'b00; tick(); check("lat_a", X_q, VA);
    S = 2'b01; tick(); check("lat_b", X_q, VB);
    S = 2'b10; tick(); check("lat_c", X_q, VC);

    // reset held two edges, X stays live
    rst = 1'b1; S = 2'b01;
    tick();
    check("rst1_x_q", X_q, 64'd0);
    check("rst1_err", {63'd0, sel_err_q}, 64'd0);
    check("rst1_x", X, VB);
    tick();
    check("rst2_x_q", X_q, 64'd0);
    check("rst2_err", {63'd0, sel_err_q}, 64'd0);
    check("rst2_x", X, VB);
    rst = 1'b0;
    tick();
    check("post_rst_x_q", X_q, VB);

    // reset overrides an illegal select
    S = 2'b11; rst = 1'b1;
    tick();
    check("rst_ill_err", {63'd0, sel_err_q}, 64'd0);
    rst = 1'b0;

    // sign-bit and bit-0 integrity
    A = 64'h8000_0000_0000_0000; S = 2'b00; #1;
    check("sign_a", X, 64'h8000_0000_0000_0000);
    C = 64'hFFFF_FFFF_FFFF_FFFE; S = 2'b10; #1;
    check("bit0_c", X, 64'hFFFF_FFFF_FFFF_FFFE);

    // random vectors against the behavioural model
    for (int i = 0; i < 10000; i++) begin
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      C = {$urandom, $urandom};
      S = 2'($urandom_range(0, 3));
      exp_x = model(A, B, C, S);
      #1;
      check("rand_x", X, exp_x);
      tick();
      check("rand_x_q", X_q, exp_x);
      check("rand_err", {63'd0, sel_err_q}, {63'd0, (S == 2'b11)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
